buttons_display_ctrl: RTL and testbench

//  Sequencer for the board's 8-LED display driven by two pushbuttons and a 4-bit DIP switch.

---
 rtl/buttons_display_ctrl.sv | 173 +++++++++++++++++
 tb/tb_buttons_display_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/buttons_display_ctrl.sv
// Two-button LED sequencer: synchronised and debounced buttons drive an IDLE/RUN/PAUSE FSM
// that steps one of four LED patterns at a DIP-selected tick rate.

module bdc_debounce #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          s0, s1, deb;
  logic [DW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s0    <= 1'b1;
      s1    <= 1'b1;
      deb   <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s0    <= raw;
      s1    <= s0;
      press <= 1'b0;
      if (s1 == deb) begin
        cnt <= '0;
      end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb   <= s1;
        cnt   <= '0;
        press <= ~s1;  // only the falling (press) edge is an event
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module buttons_display_ctrl #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int TICK_UNIT       = 75000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sw1_i,
  input  logic       sw2_i,
  input  logic [3:0] sw3_i,
  output logic [7:0] led_o,
  output logic [1:0] state_o,
  output logic [1:0] pattern_o,
  output logic       step_o
);
  localparam int PW = $clog2(16 * TICK_UNIT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

  logic [1:0] raw, press;
  assign raw = {sw2_i, sw1_i};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    bdc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk_i),
      .rst  (rst_i),
      .raw  (raw[i]),
      .press(press[i])
    );
  end

  logic e1, e2;
  assign e1 = press[0];
  assign e2 = press[1];

  state_t        state_q, state_d;
  logic [1:0]    pattern_q, pattern_d;
  logic [7:0]    led_q, led_d, adv_led;
  logic          dir_q, dir_d, adv_dir;
  logic          step, cnt_clr, tick, reload;
  logic [PW-1:0] cnt_q, period_q, next_period;

  function automatic logic [7:0] seed(input logic [1:0] p);
    case (p)
      2'd1:    seed = 8'h00;
      2'd3:    seed = 8'h55;
      default: seed = 8'h01;
    endcase
  endfunction

  assign next_period = PW'((32'(sw3_i) + 32'd1) * 32'(TICK_UNIT));
  assign tick        = (state_q == RUN) && (cnt_q == period_q - 1'b1);

  // dir=1 means shifting right in the bounce pattern
  always_comb begin
    adv_dir = dir_q;
    case (pattern_q)
      2'd0: adv_led = {led_q[6:0], led_q[7]};
      2'd1: adv_led = led_q + 8'd1;
      2'd2: begin
        adv_led = dir_q ? (led_q >> 1) : (led_q << 1);
        if (adv_led == 8'h80)      adv_dir = 1'b1;
        else if (adv_led == 8'h01) adv_dir = 1'b0;
      end
      default: adv_led = ~led_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    led_d     = led_q;
    dir_d     = dir_q;
    step      = 1'b0;
    cnt_clr   = 1'b0;
    if (e1 && e2) begin
      state_d   = IDLE;
      pattern_d = 2'd0;
      led_d     = 8'h01;
      dir_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (e1) state_d = RUN;
        RUN: begin
          if (e1) state_d = PAUSE;
          else if (e2) begin
            pattern_d = pattern_q + 2'd1;
            led_d     = seed(pattern_q + 2'd1);
            dir_d     = 1'b0;
            cnt_clr   = 1'b1;
          end else if (tick) step = 1'b1;
        end
        PAUSE: begin
          if (e1) state_d = RUN;
          else if (e2) step = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
    if (step) begin
      led_d = adv_led;
      dir_d = adv_dir;
    end
  end

  assign reload = (state_d == RUN) && ((state_q != RUN) || cnt_clr || tick);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pattern_q <= 2'd0;
      led_q     <= 8'h01;
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      period_q  <= PW'(TICK_UNIT);
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      led_q     <= led_d;
      dir_q     <= dir_d;
      if (reload) begin
        cnt_q    <= '0;
        period_q <= next_period;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign led_o     = led_q;
  assign state_o   = state_q;
  assign pattern_o = pattern_q;
  assign step_o    = step & ~rst_i;
endmodule

// File: tb/tb_buttons_display_ctrl.sv
// Directed bench for buttons_display_ctrl with short debounce and tick constants.

module tb_buttons_display_ctrl;
  logic       clk = 1'b0;
  logic       rst, sw1, sw2;
  logic [3:0] sw3;
  logic [7:0] led;
  logic [1:0] state, pattern;
  logic       step;

  int n_err = 0;
  int n_chk = 0;

  buttons_display_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_UNIT(10)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .sw1_i    (sw1),
    .sw2_i    (sw2),
    .sw3_i    (sw3),
    .led_o    (led),
    .state_o  (state),
    .pattern_o(pattern),
    .step_o   (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // returns with step_o high; the led advances on the following edge
  task automatic wait_step(output int n);
    n = 0;
    while (step !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    check("step_seen", 32'(step), 32'd1);
  endtask

  task automatic press(input logic b1, input logic b2, output int steps);
    steps = 0;
    if (b1) sw1 = 1'b0;
    if (b2) sw2 = 1'b0;
    repeat (7) begin cyc(); steps += int'(step); end
    sw1 = 1'b1;
    sw2 = 1'b1;
    repeat (8) begin cyc(); steps += int'(step); end
  endtask

  logic [7:0] p2_seq [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

  initial begin
    int n, s, changes;
    logic [7:0] exp_led, prev;
    rst = 1'b1; sw1 = 1'b1; sw2 = 1'b1; sw3 = 4'd0;
    repeat (3) cyc();
    check("rst_led", 32'(led), 32'h01);
    check("rst_state", 32'(state), 32'd0);
    check("rst_pattern", 32'(pattern), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    rst = 1'b0;
    repeat (20) cyc();
    check("hold_led", 32'(led), 32'h01);
    check("hold_state", 32'(state), 32'd0);

    // short glitch is ignored
    sw1 = 1'b0;
    repeat (3) cyc();
    sw1 = 1'b1;
    repeat (10) cyc();
    check("glitch_state", 32'(state), 32'd0);

    // press latency: RUN exactly 7 edges after the falling edge
    sw1 = 1'b0;
    repeat (6) cyc();
    check("lat6_state", 32'(state), 32'd0);
    cyc();
    check("lat7_state", 32'(state), 32'd1);
    repeat (3) cyc();
    sw1 = 1'b1;
    wait_step(n);
    check("first_step_n", 32'(n), 32'd6);
    check("p0_led0", 32'(led), 32'h01);
    cyc();
    check("p0_led1", 32'(led), 32'h02);
    check("held_state", 32'(state), 32'd1);
    exp_led = 8'h02;
    for (int i = 2; i <= 8; i++) begin
      wait_step(n);
      check("p0_period", 32'(n + 1), 32'd10);
      cyc();
      exp_led = {exp_led[6:0], exp_led[7]};
      check("p0_led", 32'(led), 32'(exp_led));
    end
    check("p0_wrap", 32'(led), 32'h01);

    // speed change mid-period takes effect at the next reload
    repeat (3) cyc();
    sw3 = 4'd3;
    wait_step(n);
    check("sw3_keep_n", 32'(n), 32'd6);
    cyc();
    check("sw3_led_a", 32'(led), 32'h02);
    wait_step(n);
    check("sw3_long_n", 32'(n), 32'd39);
    cyc();
    check("sw3_led_b", 32'(led), 32'h04);
    sw3 = 4'd0;

    // PAUSE
    press(1'b1, 1'b0, s);
    check("pause_steps", 32'(s), 32'd0);
    check("pause_state", 32'(state), 32'd2);
    changes = 0;
    prev = led;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (led !== prev || step !== 1'b0) changes++;
      prev = led;
    end
    check("pause_frozen", 32'(changes), 32'd0);
    check("pause_led", 32'(led), 32'h04);
    press(1'b0, 1'b1, s);
    check("pstep1_n", 32'(s), 32'd1);
    check("pstep1_led", 32'(led), 32'h08);
    press(1'b0, 1'b1, s);
    check("pstep2_n", 32'(s), 32'd1);
    check("pstep2_led", 32'(led), 32'h10);

    // resume, then next pattern
    press(1'b1, 1'b0, s);
    check("resume_steps", 32'(s), 32'd0);
    check("resume_state", 32'(state), 32'd1);
    wait_step(n);
    check("resume_n", 32'(n), 32'd1);
    cyc();
    check("resume_led", 32'(led), 32'h20);
    press(1'b0, 1'b1, s);
    check("p1_seed_steps", 32'(s), 32'd0);
    check("p1_pattern", 32'(pattern), 32'd1);
    check("p1_seed", 32'(led), 32'h00);
    wait_step(n); cyc();
    check("p1_led1", 32'(led), 32'h01);
    wait_step(n); cyc();
    check("p1_led2", 32'(led), 32'h02);
    for (int i = 0; i < 253; i++) begin
      wait_step(n);
      cyc();
    end
    check("p1_ff", 32'(led), 32'hFF);
    wait_step(n); cyc();
    check("p1_wrap", 32'(led), 32'h00);

    // bounce
    press(1'b0, 1'b1, s);
    check("p2_pattern", 32'(pattern), 32'd2);
    check("p2_seed", 32'(led), 32'h01);
    for (int i = 0; i < 15; i++) begin
      wait_step(n);
      cyc();
      check("p2_led", 32'(led), 32'(p2_seq[i]));
    end

    // invert
    press(1'b0, 1'b1, s);
    check("p3_pattern", 32'(pattern), 32'd3);
    check("p3_seed", 32'(led), 32'h55);
    wait_step(n); cyc();
    check("p3_led1", 32'(led), 32'hAA);
    wait_step(n); cyc();
    check("p3_led2", 32'(led), 32'h55);
    press(1'b0, 1'b1, s);
    check("p3_to_p0", 32'(pattern), 32'd0);
    check("p3_to_p0_led", 32'(led), 32'h01);

    // walk to P2, then both buttons together
    wait_step(n); cyc();
    press(1'b0, 1'b1, s);
    wait_step(n); cyc();
    press(1'b0, 1'b1, s);
    check("p2b_pattern", 32'(pattern), 32'd2);
    wait_step(n); cyc();
    check("p2b_led", 32'(led), 32'h02);
    press(1'b1, 1'b1, s);
    check("both_state", 32'(state), 32'd0);
    check("both_pattern", 32'(pattern), 32'd0);
    check("both_led", 32'(led), 32'h01);

    // reset mid-RUN
    press(1'b1, 1'b0, s);
    check("rerun_state", 32'(state), 32'd1);
    wait_step(n); cyc();
    check("rerun_led", 32'(led), 32'h02);
    repeat (4) cyc();
    rst = 1'b1;
    cyc();
    check("mrst_led", 32'(led), 32'h01);
    check("mrst_state", 32'(state), 32'd0);
    check("mrst_pattern", 32'(pattern), 32'd0);
    check("mrst_step", 32'(step), 32'd0);
    rst = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
